weight_load_ctrl: RTL
=====================

# weight_load_ctrl

Sequencer that fills the weight buffer from a serial valid/ready weight stream. On a start request it waits until the MAC array is idle, then streams exactly POF*NKX*NKY weights into consecutive buffer addresses 0..TOTAL-1 and signals completion. It sits between the host/DMA weight stream and the weight buffer's serial write port. It also gates the MAC array through `weights_valid` and flags stream-framing errors.

## Interface
- `DATA_WIDTH`, 16, width of one weight word.
- `POF`, 4, number of parallel output filters.
- `NKX`, 3, kernel width.
- `NKY`, 3, kernel height.
- Derived: `TOTAL = POF*NKX*NKY` (36); `AW = $clog2(TOTAL)` (6).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to (re)load the full weight set.
- `mac_busy`  in  1  high while the MAC array is consuming weights; no writes are issued while it is high.
- `s_valid`  in  1  weight stream word valid.
- `s_data`  in  DATA_WIDTH  weight stream word.
- `s_last`  in  1  marks the final word of a weight set.
- `s_ready`  out  1  controller accepts a stream word.
- `we`  out  1  weight buffer write enable (registered).
- `w_addr`  out  AW  weight buffer write address (registered).
- `w_data`  out  DATA_WIDTH  weight buffer write data (registered).
- `weights_valid`  out  1  buffer holds a complete, current weight set.
- `busy`  out  1  a load is pending or in progress.
- `done`  out  1  one-cycle pulse when a load completes.
- `frame_err`  out  1  sticky framing error flag.

## Operation
- FSM states: IDLE, WAIT_MAC, LOAD, FLUSH.
- **IDLE**
  - On `start` with `mac_busy=0`, go to LOAD.
  - On `start` with `mac_busy=1`, go to WAIT_MAC.
  - Either way: `weights_valid` clears, `frame_err` clears, and the beat counter `cnt` is set to 0.
- **WAIT_MAC:** `s_ready=0`. Go to LOAD on the first cycle `mac_busy=0`.
- **LOAD**
  - `s_ready=1`.
  - Each beat is accepted when `s_valid && s_ready`.
  - An accepted beat registers `we=1`, `w_addr=cnt`, `w_data=s_data` for the next cycle, and increments `cnt`.
  - On the accepted beat with `cnt==TOTAL-1`, go to FLUSH.
- **FLUSH:** `s_ready=0`. Go to IDLE next cycle, pulsing `done=1` and setting `weights_valid=1` on entry to IDLE.
- **Framing**
  - `s_last=1` on an accepted beat with `cnt!=TOTAL-1` sets `frame_err`. The load continues, and the word is still written.
  - `s_last=0` on the final beat (`cnt==TOTAL-1`) also sets `frame_err`.
  - The load always completes after exactly TOTAL beats.
- `start` while in WAIT_MAC, LOAD or FLUSH is ignored. No queuing.
- `mac_busy` rising during LOAD is not checked; the MAC array must not assert it while `weights_valid=0`.
- `busy=1` in WAIT_MAC, LOAD and FLUSH; `busy=0` in IDLE.
- `cnt` never wraps: it is AW bits wide, bounded 0..TOTAL-1, and is reset by the next start.
- `we` is low in every cycle that does not follow an accepted beat. Stalls (`s_valid=0`) leave `cnt` unchanged.

## Timing
- Reset values:
  - state IDLE, `cnt=0`.
  - `s_ready=0`, `we=0`, `w_addr=0`, `w_data=0`.
  - `weights_valid=0`, `busy=0`, `done=0`, `frame_err=0`.
- Reset mid-load:
  - Next cycle everything is in reset state and no further `we`.
  - Buffer contents are left as written; `weights_valid=0` marks them unusable.
- Start latency, with `start` at cycle t and `mac_busy=0`:
  - `busy=1` and `s_ready=1` at t+1.
  - The first accept is possible at t+1, with its `we` at t+2.
- Write latency: exactly 1 cycle from accept to `we`.
- Completion, with the final accept at cycle k:
  - `we` (addr TOTAL-1) at k+1, state FLUSH.
  - `done=1`, `weights_valid=1` and `busy=0` at k+2.
- Minimum load time with `s_valid` held high: TOTAL+2 cycles from `start` to `done`.
- `s_ready` is a function of state only and has no combinational path from `s_valid`.

## Test plan
- **Reset:** assert `rst` 2 cycles → all outputs 0, `s_ready=0`; `s_valid=1` in IDLE is never accepted and gives `we=0`.
- **Back-to-back load:** `start` at t with `mac_busy=0`, stream 0x0000..0x0023 continuously, `s_last` on word 35 → 36 `we` pulses at t+2..t+37 with `w_addr=i`, `w_data=i`; `done` and `weights_valid` at t+38; `frame_err=0`.
- **Stalls and MAC wait:**
  - `start` with `mac_busy=1` for 5 cycles → `s_ready=0` throughout and `busy=1`.
  - Toggle `s_valid` every other cycle afterwards → addresses contiguous with no gaps, 36 writes total, `done` after the 36th accept +2.
- **Framing:**
  - `s_last` on word 10 → `frame_err=1` from the write of addr 10 onward; load still completes with 36 writes.
  - Separate run with no `s_last` on word 35 → `frame_err=1` at `done`.
- **Reset mid-operation:** `rst` after 20 accepts → `we=0`, `cnt=0`, `weights_valid=0`; a new `start` reloads from addr 0.
- **Ignored start:** `start` pulsed during LOAD at beat 15 → no counter reset, load ends after 36 total writes, single `done` pulse.

Source files
------------

// File: rtl/weight_load_ctrl.sv
// Weight buffer load sequencer: waits for the MAC array to go idle, then streams
// exactly POF*NKX*NKY weights into buffer addresses 0..TOTAL-1 and flags framing errors.
module weight_load_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int POF        = 4,
  parameter int NKX        = 3,
  parameter int NKY        = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mac_busy,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  we,
  output logic [$clog2(POF*NKX*NKY)-1:0] w_addr,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  weights_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  frame_err
);

  localparam int TOTAL = POF * NKX * NKY;
  localparam int AW    = $clog2(TOTAL);
  localparam logic [AW-1:0] LAST_IDX = AW'(TOTAL - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MAC = 2'd1,
    LOAD     = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  state_t        state;
  logic [AW-1:0] cnt;

  // Ready depends only on state, so there is no combinational path from s_valid.
  assign s_ready = (state == LOAD);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      we            <= 1'b0;
      w_addr        <= '0;
      w_data        <= '0;
      weights_valid <= 1'b0;
      done          <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            weights_valid <= 1'b0;
            frame_err     <= 1'b0;
            cnt           <= '0;
            state         <= mac_busy ? WAIT_MAC : LOAD;
          end
        end
        WAIT_MAC: begin
          if (!mac_busy) state <= LOAD;
        end
        LOAD: begin
          if (s_valid) begin
            we     <= 1'b1;
            w_addr <= cnt;
            w_data <= s_data;
            if (cnt == LAST_IDX) begin
              // Final beat: the set is complete whatever s_last says; cnt holds.
              if (!s_last) frame_err <= 1'b1;
              state <= FLUSH;
            end else begin
              if (s_last) frame_err <= 1'b1;
              cnt <= cnt + AW'(1);
            end
          end
        end
        FLUSH: begin
          done          <= 1'b1;
          weights_valid <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
